// File: rtl/trig_pkg.sv
// trig_pkg: shared definitions for the trigger-board histogram readout.
//   FrameHdr       - first byte of every readout frame
//   NchDefault     - default number of channels swept
//   NhistDefault   - default histogram words per channel
//   state_e        - readout sequencer states
//   frame_len()    - bytes per frame: header, channel, 4 bytes per word, checksum
package trig_pkg;

  localparam logic [7:0]  FrameHdr     = 8'hA5;
  localparam int unsigned NchDefault   = 16;
  localparam int unsigned NhistDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSettle,
    StCapture,
    StSend,
    StClear,
    StFinish
  } state_e;

  function automatic int unsigned frame_len(int unsigned nhist);
    return 2 + 4 * nhist + 1;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer: shadows one channel's histogram words and streams them as a
// checksummed byte frame (header, channel, words big-endian, XOR) under valid/ready.
//   clk_adc, nrst    - clock, asynchronous active-low reset
//   load             - capture words/ch into the shadow buffer and start a frame
//   words            - NHIST x 32-bit histogram words (word 0 in the low bits)
//   ch               - channel number placed in byte 1
//   tx_data/tx_valid - presented byte; tx_data is 0 while not valid
//   tx_ready         - sink accepts the byte
//   last             - the presented byte is the checksum (final byte of the frame)
module byte_serializer
  import trig_pkg::*;
#(
  parameter int unsigned NHIST = NhistDefault
) (
  input  logic                clk_adc,
  input  logic                nrst,
  input  logic                load,
  input  logic [NHIST*32-1:0] words,
  input  logic [7:0]          ch,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                last
);

  localparam int unsigned     FrameLen = frame_len(NHIST);
  localparam int unsigned     IdxW     = $clog2(FrameLen);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(FrameLen - 1);

  logic [NHIST*32-1:0] shadow_q;
  logic [7:0]          ch_q;
  logic [7:0]          csum_q;
  logic [IdxW-1:0]     idx_q;
  logic                valid_q;
  logic [IdxW-1:0]     rel;
  logic [31:0]         word;
  logic [7:0]          cur_byte;
  logic                xfer;

  assign xfer     = valid_q & tx_ready;
  assign last     = valid_q & (idx_q == LastIdx);
  assign tx_valid = valid_q;
  assign tx_data  = valid_q ? cur_byte : 8'h00;

  // Payload byte idx maps to word (idx-2)/4, byte (idx-2)%4 counted from the MSB.
  always_comb begin
    rel  = idx_q - IdxW'(2);
    word = '0;
    for (int unsigned i = 0; i < NHIST; i++) begin
      if (32'(rel >> 2) == i) word = shadow_q[32*i +: 32];
    end
    case (rel[1:0])
      2'd0:    cur_byte = word[31:24];
      2'd1:    cur_byte = word[23:16];
      2'd2:    cur_byte = word[15:8];
      default: cur_byte = word[7:0];
    endcase
    if (idx_q == '0) begin
      cur_byte = FrameHdr;
    end else if (idx_q == IdxW'(1)) begin
      cur_byte = ch_q;
    end else if (idx_q == LastIdx) begin
      cur_byte = csum_q;
    end
  end

  // Checksum only advances on an accepted byte, so stalls never double-count.
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      shadow_q <= '0;
      ch_q     <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
    end else if (load) begin
      shadow_q <= words;
      ch_q     <= ch;
      csum_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b1;
    end else if (xfer) begin
      csum_q <= csum_q ^ cur_byte;
      if (idx_q == LastIdx) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + IdxW'(1);
      end
    end
  end

endmodule

// File: rtl/histo_readout_ctrl.sv
// histo_readout_ctrl: sweeps the histogram channel select, waits out the
// select-to-data pipeline, captures each channel's words outside the calibration
// window and streams them as byte frames; optionally clears the histograms after.
//   clk_adc, nrst         - clock, asynchronous active-low reset
//   start, clear_after    - readout request (IDLE only) and clear-after-sweep flag
//   spareleft             - calibration window; blocks capture and clear counting
//   histosout             - NHIST x 32-bit words of the selected channel
//   histostosend          - channel select to the datapath (holds in IDLE)
//   resethist             - histogram clear to the datapath
//   tx_data/valid/ready   - byte stream to the host link
//   busy, done            - sweep in progress / one-cycle end-of-sweep pulse
//   frame_count           - completed sweeps, wrapping
module histo_readout_ctrl
  import trig_pkg::*;
#(
  parameter int unsigned NCH        = NchDefault,
  parameter int unsigned NHIST      = NhistDefault,
  parameter int unsigned SETTLE     = 3,
  parameter int unsigned CLEAR_HOLD = 2
) (
  input  logic                clk_adc,
  input  logic                nrst,
  input  logic                start,
  input  logic                clear_after,
  input  logic                spareleft,
  input  logic [NHIST*32-1:0] histosout,
  output logic [7:0]          histostosend,
  output logic                resethist,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_count
);

  state_e      state_q, state_d;
  logic [7:0]  ch_q, ch_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        clr_q, clr_d;
  logic [15:0] frame_count_q;
  logic        load;
  logic        last;
  logic        frame_end;

  byte_serializer #(
    .NHIST (NHIST)
  ) u_ser (
    .clk_adc  (clk_adc),
    .nrst     (nrst),
    .load     (load),
    .words    (histosout),
    .ch       (ch_q),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .last     (last)
  );

  assign frame_end = tx_valid & tx_ready & last;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr_d   = clear_after;
          ch_d    = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        cnt_d   = 8'(SETTLE - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCapture;
        else             cnt_d   = cnt_q - 8'd1;
      end
      StCapture: begin
        // Words 0-3 tear while the calibration window is open.
        if (!spareleft) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (frame_end) begin
          if (ch_q != 8'(NCH - 1)) begin
            ch_d    = ch_q + 8'd1;
            state_d = StSelect;
          end else if (clr_q) begin
            cnt_d   = '0;
            state_d = StClear;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StClear: begin
        // The datapath ignores the clear during the window, so those cycles don't count.
        if (!spareleft) begin
          if (cnt_q == 8'(CLEAR_HOLD - 1)) state_d = StFinish;
          else                             cnt_d   = cnt_q + 8'd1;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StIdle;
      ch_q          <= '0;
      cnt_q         <= '0;
      clr_q         <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      if (state_q == StFinish) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  // ch only changes on entry to SELECT, so it doubles as the registered select.
  assign histostosend = ch_q;
  assign resethist    = (state_q == StClear);
  assign busy         = (state_q != StIdle) && (state_q != StFinish);
  assign done         = (state_q == StFinish);
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_histo_readout_ctrl.sv
module tb_histo_readout_ctrl;

  localparam int NCH        = 16;
  localparam int NHIST      = 8;
  localparam int SETTLE     = 3;
  localparam int CLEAR_HOLD = 2;
  localparam int FLEN       = 2 + 4 * NHIST + 1;
  localparam int SWEEP_LAT  = NCH * (SETTLE + 2 + FLEN) + 1;
  localparam int TIMEOUT    = 6000;

  logic                clk_adc     = 1'b0;
  logic                nrst        = 1'b1;
  logic                start       = 1'b0;
  logic                clear_after = 1'b0;
  logic                spareleft   = 1'b0;
  logic                tx_ready    = 1'b0;
  logic [NHIST*32-1:0] histosout;
  logic [7:0]          histostosend;
  logic                resethist;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                busy;
  logic                done;
  logic [15:0]         frame_count;

  histo_readout_ctrl #(
    .NCH        (NCH),
    .NHIST      (NHIST),
    .SETTLE     (SETTLE),
    .CLEAR_HOLD (CLEAR_HOLD)
  ) dut (
    .clk_adc      (clk_adc),
    .nrst         (nrst),
    .start        (start),
    .clear_after  (clear_after),
    .spareleft    (spareleft),
    .histosout    (histosout),
    .histostosend (histostosend),
    .resethist    (resethist),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .frame_count  (frame_count)
  );

  always #5 clk_adc = ~clk_adc;

  typedef struct {
    bit          clr;
    int          ready_pct;
    int          blk_ch;     // -1: no calibration window
    int          blk_len;
    bit          tog;        // spareleft 1,0,1,0 during CLEAR
    bit          poke;       // start while busy and on the done cycle
    logic [31:0] seed0;
    logic [31:0] seed1;      // data seed after the window
    int          exp_rst;    // expected resethist-high cycles
    int          exp_lat;    // expected start-to-done cycles, -1 = unchecked
  } vec_t;

  vec_t vecs[6];

  int          checks = 0;
  int          errors = 0;
  int          ready_pct = 100;
  int          blk_ch = -1;
  int          blk_len = 0;
  int          blk_left = 0;
  bit          blk_armed = 0;
  bit          in_window = 0;
  bit          tog_armed = 0;
  int          tog_idx = 0;
  logic [31:0] seed = '0;
  logic [31:0] seed_after = '0;
  logic [7:0]  rx[$];
  int          done_cnt = 0;
  int          rst_cyc = 0;
  int          win_valid = 0;
  bit          stall_q = 0;
  logic [7:0]  stall_data = '0;
  logic [15:0] exp_fc = '0;
  logic [7:0]  sel_p1 = '0;
  logic [7:0]  sel_p2 = '0;

  function automatic logic [31:0] hword(int c, int w, logic [31:0] s);
    return s ^ ((32'(c) << 8) + 32'(w));
  endfunction

  function automatic vec_t mk(bit clr, int rp, int bch, int blen, bit tog, bit poke,
                              logic [31:0] s0, logic [31:0] s1, int erst, int elat);
    vec_t v;
    v.clr = clr; v.ready_pct = rp; v.blk_ch = bch; v.blk_len = blen; v.tog = tog;
    v.poke = poke; v.seed0 = s0; v.seed1 = s1; v.exp_rst = erst; v.exp_lat = elat;
    return v;
  endfunction

  // Datapath stand-in: two register stages from select to words.
  always @(posedge clk_adc) begin
    sel_p2 <= sel_p1;
    sel_p1 <= histostosend;
  end

  always_comb begin
    histosout = '0;
    for (int w = 0; w < NHIST; w++) histosout[w*32 +: 32] = hword(int'(sel_p2), w, seed);
  end

  task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", what, got, exp);
    end
  endtask

  // Input driver, just after each rising edge.
  initial forever begin
    @(posedge clk_adc);
    #1;
    tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
    if (blk_armed && busy && histostosend == 8'(blk_ch)) begin
      blk_armed = 0;
      blk_left  = blk_len;
    end
    in_window = (blk_left > 0);
    if (blk_left > 0) begin
      spareleft = 1'b1;
      if (blk_left == 1) seed = seed_after;
      blk_left--;
    end else if (tog_armed && resethist) begin
      spareleft = (tog_idx % 2 == 0);
      tog_idx++;
      if (tog_idx == 4) tog_armed = 0;
    end else begin
      spareleft = 1'b0;
    end
  end

  // Monitor on the falling edge.
  initial forever begin
    @(negedge clk_adc);
    if (!nrst) begin
      stall_q = 0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!(tx_valid && tx_data == stall_data)) begin
          errors++;
          $display("FAIL hold under stall: got valid=%0b data=0x%0h, expected valid=1 data=0x%0h",
                   tx_valid, tx_data, stall_data);
        end
      end
      if (in_window && tx_valid) win_valid++;
      if (tx_valid && tx_ready) rx.push_back(tx_data);
      if (done) done_cnt++;
      if (resethist) rst_cyc++;
      stall_q    = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  task automatic run_sweep(input vec_t v, input int id);
    logic [7:0]  exp_q[$];
    logic [31:0] s;
    logic [31:0] wv;
    logic [7:0]  x;
    int          n;
    int          bad;
    bit          got_done;

    exp_q = {};
    for (int c = 0; c < NCH; c++) begin
      s = (v.blk_ch >= 0 && c >= v.blk_ch) ? v.seed1 : v.seed0;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(c));
      x = 8'hA5 ^ 8'(c);
      for (int w = 0; w < NHIST; w++) begin
        wv = hword(c, w, s);
        for (int k = 3; k >= 0; k--) begin
          exp_q.push_back(wv[8*k +: 8]);
          x = x ^ wv[8*k +: 8];
        end
      end
      exp_q.push_back(x);
    end

    @(posedge clk_adc);
    #2;
    ready_pct = v.ready_pct; seed = v.seed0; seed_after = v.seed1;
    blk_ch = v.blk_ch; blk_len = v.blk_len; blk_left = 0; blk_armed = (v.blk_ch >= 0);
    tog_armed = v.tog; tog_idx = 0;
    rx = {}; done_cnt = 0; rst_cyc = 0; win_valid = 0;
    clear_after = v.clr;
    start = 1'b1;
    @(posedge clk_adc);
    #2;
    start = 1'b0;
    clear_after = 1'b0;
    check($sformatf("sweep%0d busy after start", id), 32'(busy), 32'd1);
    check($sformatf("sweep%0d select after start", id), 32'(histostosend), 32'd0);

    got_done = 0;
    for (n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk_adc);
      if (done) begin
        got_done = 1;
        break;
      end
      if (v.poke && n == 100) start = 1'b1;
      @(posedge clk_adc);
      #2;
      start = 1'b0;
    end
    check($sformatf("sweep%0d done within bound", id), 32'(got_done), 32'd1);
    if (got_done) begin
      if (v.exp_lat >= 0) check($sformatf("sweep%0d latency", id), 32'(n), 32'(v.exp_lat));
      check($sformatf("sweep%0d busy at done", id), 32'(busy), 32'd0);
      if (v.poke) start = 1'b1;
      @(posedge clk_adc);
      #2;
      start = 1'b0;
    end
    exp_fc = exp_fc + 16'd1;
    repeat (20) @(posedge clk_adc);
    #2;
    check($sformatf("sweep%0d done pulses", id), 32'(done_cnt), 32'd1);
    check($sformatf("sweep%0d resethist cycles", id), 32'(rst_cyc), 32'(v.exp_rst));
    check($sformatf("sweep%0d frame_count", id), 32'(frame_count), 32'(exp_fc));
    check($sformatf("sweep%0d idle after", id), 32'(busy), 32'd0);
    check($sformatf("sweep%0d valid in window", id), 32'(win_valid), 32'd0);
    check($sformatf("sweep%0d byte count", id), 32'(rx.size()), 32'(exp_q.size()));
    if (rx.size() == exp_q.size()) begin
      for (int f = 0; f < NCH; f++) begin
        bad = -1;
        x = '0;
        for (int b = 0; b < FLEN; b++) begin
          if (bad < 0 && rx[f*FLEN+b] !== exp_q[f*FLEN+b]) bad = b;
          x = x ^ rx[f*FLEN+b];
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL sweep%0d frame %0d byte %0d: got 0x%0h, expected 0x%0h", id, f, bad,
                   rx[f*FLEN+bad], exp_q[f*FLEN+bad]);
        end
        check($sformatf("sweep%0d frame %0d xor", id, f), 32'(x), 32'd0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " histostosend"}, 32'(histostosend), 32'd0);
    check({tag, " resethist"}, 32'(resethist), 32'd0);
    check({tag, " tx_data"}, 32'(tx_data), 32'd0);
    check({tag, " tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " frame_count"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    vec_t rv;
    int   n;

    //           clr rdy  blk len tog poke seed0         seed1         rst lat
    vecs[0] = mk(0, 100, -1,   0, 0,  0,   32'h0,        32'h0,        0, SWEEP_LAT);
    vecs[1] = mk(0,  30, -1,   0, 0,  0,   32'h0,        32'h0,        0, -1);
    vecs[2] = mk(0, 100,  5, 100, 0,  0,   32'h0,        32'h5A5A0000, 0, -1);
    vecs[3] = mk(1, 100, -1,   0, 0,  0,   32'h0,        32'h0,        CLEAR_HOLD,
                 SWEEP_LAT + CLEAR_HOLD);
    vecs[4] = mk(1, 100, -1,   0, 1,  0,   32'h0,        32'h0,        4, SWEEP_LAT + 4);
    vecs[5] = mk(0, 100, -1,   0, 0,  1,   32'h11223344, 32'h0,        0, SWEEP_LAT);

    #1 nrst = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk_adc);
    #2 nrst = 1'b1;

    for (int i = 0; i < 6; i++) run_sweep(vecs[i], i);

    for (int i = 0; i < 3; i++) begin
      rv.clr       = bit'($urandom_range(0, 1));
      rv.ready_pct = int'($urandom_range(20, 100));
      rv.blk_ch    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, NCH - 1)) : -1;
      rv.blk_len   = int'($urandom_range(10, 60));
      rv.tog       = 0;
      rv.poke      = 0;
      rv.seed0     = $urandom;
      rv.seed1     = $urandom;
      rv.exp_rst   = rv.clr ? CLEAR_HOLD : 0;
      rv.exp_lat   = -1;
      run_sweep(rv, 10 + i);
    end

    // Reset while byte 12 of channel 3 is on the bus.
    @(posedge clk_adc);
    #2;
    ready_pct = 100; seed = '0; blk_armed = 0; blk_left = 0; tog_armed = 0; rx = {};
    start = 1'b1;
    @(posedge clk_adc);
    #2;
    start = 1'b0;
    n = 0;
    while (rx.size() < 3 * FLEN + 12 && n < TIMEOUT) begin
      @(posedge clk_adc);
      #2;
      n++;
    end
    check("reached ch3 byte 12", 32'(rx.size()), 32'(3 * FLEN + 12));
    check("mid-frame valid", 32'(tx_valid), 32'd1);
    nrst = 1'b0;
    #1 check_all_zero("async reset");
    repeat (3) @(posedge clk_adc);
    #2 nrst = 1'b1;
    exp_fc = '0;
    run_sweep(vecs[0], 20);

    // Counter wrap.
    @(negedge clk_adc);
    force dut.frame_count_q = 16'hFFFF;
    @(posedge clk_adc);
    #2;
    release dut.frame_count_q;
    exp_fc = 16'hFFFF;
    run_sweep(vecs[0], 21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/histo_readout_ctrl.md
# histo_readout_ctrl

Readout sequencer for the trigger board's per-channel monitoring histograms. On a start request it steps the histogram channel select through all channels and waits out the select-to-data pipeline. It captures the eight 32-bit histogram words per channel and streams them as checksummed byte frames over a valid/ready interface to the host link. It can optionally clear the trigger-count histograms afterwards. It sits on `clk_adc` beside the trigger/calibration datapath and replaces the slow-clock direct drive of `histostosend` and `resethist`.

## Interface
- `NCH`, 16, number of channels swept; select values 0..NCH-1
- `NHIST`, 8, histogram words per channel
- `SETTLE`, 3, cycles from select change to valid `histosout`; covers the datapath's 2-register path plus margin
- `CLEAR_HOLD`, 2, `clk_adc` cycles with `spareleft`=0 during which `resethist` must be high
- `clk_adc` in 1 — sole clock
- `nrst` in 1 — asynchronous, active-low reset
- `start` in 1 — single-cycle readout request
- `clear_after` in 1 — sampled with an accepted `start`; 1 = clear histograms after the sweep
- `spareleft` in 1 — calibration window flag from the datapath
- `histosout` in NHIST×32 — histogram words for the selected channel
- `histostosend` out 8 — channel select to the datapath
- `resethist` out 1 — histogram clear to the datapath
- `tx_data` out 8 — stream byte
- `tx_valid` out 1 — stream byte valid
- `tx_ready` in 1 — sink accepts the byte
- `busy` out 1 — high from an accepted `start` until `done`
- `done` out 1 — one-cycle pulse at the end of the sweep
- `frame_count` out 16 — completed sweeps, wraps at 0xFFFF→0

## Operation
- States: IDLE, SELECT, SETTLE, CAPTURE, SEND, CLEAR, FINISH.
- IDLE: `start`=1 latches `clear_after` into `clr_q`, sets ch=0 → SELECT. `start` is ignored outside IDLE.
- SELECT: drive `histostosend`=ch, load settle counter with SETTLE-1 → SETTLE.
- SETTLE: decrement the counter; at 0 → CAPTURE.
- CAPTURE: if `spareleft`=1, wait; histos 0–3 tear during calibration. If `spareleft`=0, register all NHIST words into the shadow buffer in one cycle, reset the byte index and checksum → SEND.
- SEND frame of 2+4·NHIST+1 bytes (35 for defaults):
  - byte 0: 0xA5
  - byte 1: ch
  - then word 0..NHIST-1, each big-endian
  - last byte: XOR of all preceding frame bytes
- After the last byte of a frame:
  - ch<NCH-1: ch+1 → SELECT
  - otherwise, `clr_q`=1 → CLEAR
  - otherwise → FINISH
- CLEAR: `resethist`=1; count cycles with `spareleft`=0. After CLEAR_HOLD counted cycles → FINISH. Cycles with `spareleft`=1 are not counted, because the datapath ignores clear there.
- FINISH: `done`=1 for 1 cycle, `frame_count`+1 → IDLE.
- `histostosend` holds its last value in IDLE. Upper bits are zero-extended from ch.
- Reset (async, any state): state IDLE and all outputs 0 (`histostosend`, `resethist`, `tx_data`, `tx_valid`, `busy`, `done`, `frame_count`). Shadow buffer and checksum are cleared. A partial frame is abandoned; no resume.

## Timing
- `start` in cycle 0 → `busy` and new `histostosend` registered at the cycle-1 edge. Capture occurs SETTLE cycles after the select change.
- First `tx_valid` is the cycle after CAPTURE. Sweep latency with `tx_ready` tied high and `spareleft`=0: NCH·(SETTLE+2+frame length) + 1, plus CLEAR_HOLD when clearing.
- Handshake:
  - A byte transfers on a cycle with `tx_valid`∧`tx_ready`.
  - While `tx_valid`∧¬`tx_ready`, `tx_data` is stable and `tx_valid` stays high.
  - Back-to-back bytes are supported at 1 byte/cycle.
  - `tx_valid` drops only between frames, from the last byte until the next CAPTURE.
- The checksum accumulates on transfer, not on presentation.
- `busy` falls in the same cycle `done` pulses.
- `start` arriving on the same cycle as `done` is ignored. A new sweep requires `start` in IDLE.

## Structure
- Shared package `trig_pkg`:
  - frame header constant 0xA5
  - NCH/NHIST defaults
  - state enum
  - frame-length function
- One sub-module `byte_serializer`: takes NHIST×32 shadow words plus the header and channel. It presents bytes under valid/ready, runs the XOR checksum, and signals `last`. The FSM stays in `histo_readout_ctrl`.

## Test plan
- Basic sweep: channel c, word w preloaded with 0x0100·c+w; `tx_ready`=1; `start`.
  - 16 frames of 35 bytes, each beginning A5, c, 00 00 0c 00…
  - Correct XOR per frame.
  - `done` once, `frame_count`=1, `resethist` never high.
- Backpressure: `tx_ready` random 30% high.
  - Byte stream is identical to the basic sweep.
  - No `tx_data` change while valid∧¬ready.
  - No duplicated or dropped bytes.
- Calibration blocking: `spareleft`=1 for 100 cycles when ch=5 reaches CAPTURE.
  - No capture until `spareleft` falls.
  - Frame 5 words come from post-window data.
- Clear with window: `clear_after`=1; `spareleft` toggles 1,0,1,0 during CLEAR.
  - `resethist` stays high until 2 `spareleft`=0 cycles have elapsed, then `done`.
- Reset mid-frame: `nrst` low at byte 12 of ch=3.
  - All outputs 0 asynchronously.
  - After release, a `start` produces a full fresh sweep from ch=0.
  - `frame_count` restarts from 0.
- Ignored start / wrap: `start` while busy and on the `done` cycle → no second sweep. Preload `frame_count`=0xFFFF via 65535 sweeps (or force) → 0 after the next sweep.
